// File: rtl/mmap_obi_arbiter.sv
// Two-master / three-slave OBI arbiter and address decoder, one transaction in flight.
// Optional response timeout: define MMAP_OBI_ARBITER_TIMEOUT_EN.
module mmap_obi_arbiter #(
    parameter logic [31:0] SRAM_BASE_P    = 32'h1C00_0000,
    parameter logic [31:0] SRAM_LEN_P     = 32'h000F_C000,
    parameter logic [31:0] DEBUG_BASE_P   = 32'h1A11_0000,
    parameter logic [31:0] DEBUG_LEN_P    = 32'h0000_1000,
    parameter logic [31:0] ROM_BASE_P     = 32'h1A00_0000,
    parameter logic [31:0] ROM_LEN_P      = 32'h0010_0000,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       m_req_i,
    input  logic [1:0]       m_we_i,
    input  logic [1:0][3:0]  m_be_i,
    input  logic [1:0][31:0] m_addr_i,
    input  logic [1:0][31:0] m_wdata_i,
    output logic [1:0]       m_gnt_o,
    output logic [1:0]       m_rvalid_o,
    output logic [31:0]      m_rdata_o,
    output logic             m_err_o,
    output logic [2:0]       s_req_o,
    output logic             s_we_o,
    output logic [3:0]       s_be_o,
    output logic [31:0]      s_addr_o,
    output logic [31:0]      s_wdata_o,
    input  logic [2:0]       s_gnt_i,
    input  logic [2:0]       s_rvalid_i,
    input  logic [2:0][31:0] s_rdata_i
);

    typedef enum logic [1:0] {IDLE, WAIT_RSP, ERR_RSP} state_e;

    state_e     state_q, state_d;
    logic       winner_q, winner_d;
    logic [1:0] sel_q, sel_d;
    logic       rr_q, rr_d;
    logic       lock_q, lock_d;
    logic       lock_m_q, lock_m_d;

    logic        win, active, mapped;
    logic [1:0]  dsel;
    logic [31:0] waddr;
    logic        hit_sram, hit_debug, hit_rom;

`ifdef MMAP_OBI_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
`endif

    // A locked master keeps the slave bus stable until its slave grants.
    always_comb begin
        win = 1'b0;
        if (lock_q)                win = lock_m_q;
        else if (m_req_i == 2'b10) win = 1'b1;
        else if (m_req_i == 2'b11) win = rr_q;
    end

    assign active = lock_q | (|m_req_i);
    assign waddr  = m_addr_i[win];

    // Wrapping subtraction makes addresses below a base miss.
    assign hit_sram  = (waddr - SRAM_BASE_P)  < SRAM_LEN_P;
    assign hit_debug = (waddr - DEBUG_BASE_P) < DEBUG_LEN_P;
    assign hit_rom   = (waddr - ROM_BASE_P)   < ROM_LEN_P;
    assign mapped    = hit_sram | hit_debug | hit_rom;

    always_comb begin
        dsel = 2'd0;
        if (hit_sram)       dsel = 2'd0;
        else if (hit_debug) dsel = 2'd1;
        else if (hit_rom)   dsel = 2'd2;
    end

    assign s_addr_o  = waddr;
    assign s_we_o    = m_we_i[win];
    assign s_be_o    = m_be_i[win];
    assign s_wdata_o = m_wdata_i[win];

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_m_d   = lock_m_q;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = 1'b0;
        s_req_o    = '0;
`ifdef MMAP_OBI_ARBITER_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (active) begin
                    if (mapped) begin
                        s_req_o[dsel] = 1'b1;
                        if (s_gnt_i[dsel]) begin
                            m_gnt_o[win] = 1'b1;
                            winner_d     = win;
                            sel_d        = dsel;
                            rr_d         = ~win;
                            lock_d       = 1'b0;
                            state_d      = WAIT_RSP;
`ifdef MMAP_OBI_ARBITER_TIMEOUT_EN
                            cnt_d        = '0;
`endif
                        end else begin
                            lock_d   = 1'b1;
                            lock_m_d = win;
                        end
                    end else begin
                        m_gnt_o[win] = 1'b1;
                        winner_d     = win;
                        rr_d         = ~win;
                        lock_d       = 1'b0;
                        state_d      = ERR_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (s_rvalid_i[sel_q]) begin
                    m_rvalid_o[winner_q] = 1'b1;
                    m_rdata_o            = s_rdata_i[sel_q];
                    state_d              = IDLE;
                end
`ifdef MMAP_OBI_ARBITER_TIMEOUT_EN
                else if (cnt_q + 16'd1 >= TO_LIMIT) begin
                    state_d = ERR_RSP;
                end
                cnt_d = cnt_q + 16'd1;
`endif
            end
            ERR_RSP: begin
                m_rvalid_o[winner_q] = 1'b1;
                m_rdata_o            = ERR_RDATA;
                m_err_o              = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            m_gnt_o    = '0;
            m_rvalid_o = '0;
            m_rdata_o  = '0;
            m_err_o    = 1'b0;
            s_req_o    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            sel_q    <= 2'd0;
            rr_q     <= 1'b0;
            lock_q   <= 1'b0;
            lock_m_q <= 1'b0;
`ifdef MMAP_OBI_ARBITER_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            lock_q   <= lock_d;
            lock_m_q <= lock_m_d;
`ifdef MMAP_OBI_ARBITER_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmap_obi_arbiter.sv
// Scoreboard bench for mmap_obi_arbiter: tasks queue expected responses, a monitor pops them.
module tb_mmap_obi_arbiter;

`ifdef MMAP_OBI_ARBITER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       m_req_i, m_we_i;
    logic [1:0][3:0]  m_be_i;
    logic [1:0][31:0] m_addr_i, m_wdata_i;
    logic [1:0]       m_gnt_o, m_rvalid_o;
    logic [31:0]      m_rdata_o;
    logic             m_err_o;
    logic [2:0]       s_req_o;
    logic             s_we_o;
    logic [3:0]       s_be_o;
    logic [31:0]      s_addr_o, s_wdata_o;
    logic [2:0]       s_gnt_i, s_rvalid_i;
    logic [2:0][31:0] s_rdata_i;

    mmap_obi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o), .s_req_o(s_req_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  mv;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Slave model: every slave answers an accepted request after rsp_delay cycles.
    int          rsp_delay = 1;
    bit          no_rsp = 0;
    bit          pend = 0;
    int          dly = 0;
    int          rk = 0;
    logic [31:0] rd = '0;

    function automatic logic [31:0] sdata(int k, logic [31:0] a);
        case (k)
            0:       return a ^ 32'h5A5A_0000;
            1:       return a ^ 32'h0F0F_0000;
            default: return a ^ 32'h3C3C_0000;
        endcase
    endfunction

    always @(negedge clk_i) begin
        if ((s_req_o & s_gnt_i) != 3'b000 && !no_rsp) begin
            pend = 1;
            dly  = rsp_delay;
            for (int k = 0; k < 3; k++)
                if (s_req_o[k] && s_gnt_i[k]) begin
                    rk = k;
                    rd = sdata(k, s_addr_o);
                end
        end
    end

    always @(posedge clk_i) begin
        #1;
        s_rvalid_i = '0;
        if (pend) begin
            dly--;
            if (dly == 0) begin
                s_rvalid_i[rk] = 1'b1;
                s_rdata_i[rk]  = rd;
                pend = 0;
            end
        end
    end

    // Response monitor
    always @(negedge clk_i) begin
        exp_t e;
        checks++;
        if (m_rvalid_o != 2'b00) begin
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rvalid=%b rdata=%h err=%b, none expected",
                         m_rvalid_o, m_rdata_o, m_err_o);
            end else begin
                e = q.pop_front();
                if ({m_rvalid_o, m_rdata_o, m_err_o} !== {e.mv, e.data, e.err}) begin
                    errors++;
                    $display("FAIL rsp: rvalid=%b rdata=%h err=%b, expected rvalid=%b rdata=%h err=%b",
                             m_rvalid_o, m_rdata_o, m_err_o, e.mv, e.data, e.err);
                end
            end
        end else if (m_rdata_o !== 32'h0 || m_err_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_bus: rdata=%h err=%b, expected 0/0", m_rdata_o, m_err_o);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(logic [1:0] mv, logic [31:0] data, logic err);
        exp_t e;
        e.mv = mv; e.data = data; e.err = err;
        q.push_back(e);
    endtask

    task automatic drive(int m, logic [31:0] a, logic we, logic [3:0] be, logic [31:0] wd);
        m_req_i[m]   = 1'b1;
        m_addr_i[m]  = a;
        m_we_i[m]    = we;
        m_be_i[m]    = be;
        m_wdata_i[m] = wd;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d responses outstanding, expected 0", name, q.size());
            q.delete();
        end
        cyc();
    endtask

    task automatic chk_gnt(string name, logic [1:0] g, logic [2:0] sr);
        @(negedge clk_i);
        checks++;
        if (m_gnt_o !== g || s_req_o !== sr) begin
            errors++;
            $display("FAIL %s: gnt=%b s_req=%b, expected gnt=%b s_req=%b", name, m_gnt_o, s_req_o, g, sr);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc(); cyc();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(0, 32'h1C00_0000, 1'b0, 4'hF, '0);
        drive(1, 32'h1B00_0000, 1'b0, 4'hF, '0);
        cyc();
        @(negedge clk_i);
        checks++;
        if ({m_gnt_o, m_rvalid_o, s_req_o, m_rdata_o, m_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b rvalid=%b s_req=%b rdata=%h err=%b, expected all 0",
                     m_gnt_o, m_rvalid_o, s_req_o, m_rdata_o, m_err_o);
        end
        cyc();
        m_req_i = '0;
        rst_i   = 1'b0;
        cyc();
    endtask

    task automatic test_single_read();
        rsp_delay = 2;
        drive(0, 32'h1C00_0010, 1'b0, 4'hF, '0);
        push(2'b01, sdata(0, 32'h1C00_0010), 1'b0);
        chk_gnt("single_gnt", 2'b01, 3'b001);
        checks++;
        if (s_addr_o !== 32'h1C00_0010 || s_we_o !== 1'b0) begin
            errors++;
            $display("FAIL single_addr: addr=%h we=%b, expected 1c000010/0", s_addr_o, s_we_o);
        end
        cyc();
        m_req_i = '0;
        chk_gnt("single_wait", 2'b00, 3'b000);
        drain("single");
        rsp_delay = 1;
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        do_reset();
        drive(0, 32'h1C00_0100, 1'b0, 4'hF, '0);
        drive(1, 32'h1C00_0200, 1'b0, 4'hF, '0);
        for (int i = 0; i < 2; i++) begin
            push(2'b01, sdata(0, 32'h1C00_0100), 1'b0);
            push(2'b10, sdata(0, 32'h1C00_0200), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            g = (i % 4 == 0) ? 2'b01 : (i % 4 == 2) ? 2'b10 : 2'b00;
            chk_gnt($sformatf("rr_c%0d", i), g, (g != 2'b00) ? 3'b001 : 3'b000);
            cyc();
        end
        m_req_i = '0;
        drain("rr");
    endtask

    task automatic test_unmapped();
        drive(1, 32'h1B00_0000, 1'b0, 4'hF, '0);
        push(2'b10, 32'hDEAD_BEEF, 1'b1);
        chk_gnt("unmapped_gnt", 2'b10, 3'b000);
        cyc();
        m_req_i = '0;
        drain("unmapped");
    endtask

    task automatic test_lock();
        s_gnt_i = 3'b101;
        drive(0, 32'h1A11_0004, 1'b0, 4'hF, '0);
        drive(1, 32'h1A00_0040, 1'b0, 4'hF, '0);
        push(2'b01, sdata(1, 32'h1A11_0004), 1'b0);
        push(2'b10, sdata(2, 32'h1A00_0040), 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) s_gnt_i = 3'b111;
            chk_gnt($sformatf("lock_c%0d", i), (i == 3) ? 2'b01 : 2'b00, 3'b010);
            checks++;
            if (s_addr_o !== 32'h1A11_0004) begin
                errors++;
                $display("FAIL lock_addr_c%0d: addr=%h, expected 1a110004", i, s_addr_o);
            end
            cyc();
        end
        m_req_i[0] = 1'b0;
        chk_gnt("lock_wait", 2'b00, 3'b000);
        cyc();
        chk_gnt("lock_m1_gnt", 2'b10, 3'b100);
        cyc();
        m_req_i = '0;
        drain("lock");
    endtask

    task automatic test_boundary();
        logic [31:0] addrs[4] = '{32'h1C0F_BFFC, 32'h1C0F_C000, 32'h1A0F_FFFC, 32'h1A11_1000};
        logic [2:0]  sreq[4]  = '{3'b001, 3'b000, 3'b100, 3'b000};
        for (int i = 0; i < 4; i++) begin
            drive(0, addrs[i], 1'b0, 4'hF, '0);
            if (sreq[i] == 3'b000) push(2'b01, 32'hDEAD_BEEF, 1'b1);
            else push(2'b01, sdata(sreq[i] == 3'b001 ? 0 : 2, addrs[i]), 1'b0);
            chk_gnt($sformatf("bound_%h", addrs[i]), 2'b01, sreq[i]);
            cyc();
            m_req_i = '0;
            drain("bound");
        end
    endtask

    task automatic test_write();
        drive(1, 32'h1A00_0080, 1'b1, 4'b0110, 32'hCAFE_F00D);
        push(2'b10, sdata(2, 32'h1A00_0080), 1'b0);
        chk_gnt("write_gnt", 2'b10, 3'b100);
        checks++;
        if ({s_we_o, s_be_o, s_wdata_o, s_addr_o} !== {1'b1, 4'b0110, 32'hCAFE_F00D, 32'h1A00_0080}) begin
            errors++;
            $display("FAIL write_fields: we=%b be=%b wdata=%h addr=%h, expected 1/0110/cafef00d/1a000080",
                     s_we_o, s_be_o, s_wdata_o, s_addr_o);
        end
        cyc();
        m_req_i = '0;
        drain("write");
    endtask

    task automatic test_reset_mid();
        rsp_delay = 3;
        drive(0, 32'h1C00_0040, 1'b0, 4'hF, '0);
        chk_gnt("rstmid_gnt", 2'b01, 3'b001);
        cyc();
        m_req_i = '0;
        rst_i   = 1'b1;
        cyc();
        rst_i   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++;
            if ({m_gnt_o, m_rvalid_o, s_req_o} !== '0) begin
                errors++;
                $display("FAIL rstmid_c%0d: gnt=%b rvalid=%b s_req=%b, expected 0", i, m_gnt_o, m_rvalid_o, s_req_o);
            end
            cyc();
        end
        rsp_delay = 1;
    endtask

`ifdef MMAP_OBI_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        no_rsp = 1;
        drive(0, 32'h1C00_0080, 1'b0, 4'hF, '0);
        push(2'b01, 32'hDEAD_BEEF, 1'b1);
        chk_gnt("timeout_gnt", 2'b01, 3'b001);
        cyc();
        m_req_i = '0;
        for (int i = 0; i < 6 && q.size() != 0; i++) cyc();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL timeout_rsp: no error response within 6 cycles, expected one");
            q.delete();
        end
        no_rsp = 0;
        cyc();
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        m_req_i = '0; m_we_i = '0; m_be_i = '0; m_addr_i = '0; m_wdata_i = '0;
        s_gnt_i = 3'b111; s_rvalid_i = '0; s_rdata_i = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_unmapped();
        test_lock();
        test_boundary();
        test_write();
        test_reset_mid();
`ifdef MMAP_OBI_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
